// File: rtl/bist_ctrl.sv
// BIST session controller: drives a 5-bit LFSR pattern stream to the CUT and
// compacts its 1-bit response into a 4-bit SISR signature, then checks it against a golden value.
module bist_ctrl #(
  parameter int unsigned N_PAT = 31
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_resp,
  input  logic [3:0] i_exp_sig,
  output logic [4:0] o_pat,
  output logic       o_pat_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] SEED = 5'b11111;
  localparam logic [4:0] LAST = 5'(N_PAT - 1);

  state_t     r_state;
  logic [4:0] r_pat;
  logic [3:0] r_sig;
  logic [4:0] r_cnt;
  logic       r_pat_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;

  logic [4:0] w_pat_nxt;
  logic [3:0] w_sig_nxt;

  // Feedback taps give a maximal-length (period 31) sequence from the all-ones seed.
  assign w_pat_nxt = {r_pat[3], r_pat[2], r_pat[1] ^ r_pat[4], r_pat[0], r_pat[4]};
  assign w_sig_nxt = {r_sig[2], r_sig[1], r_sig[3] ^ r_sig[0], r_sig[3] ^ i_resp};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pat       <= SEED;
      r_sig       <= 4'b0000;
      r_cnt       <= 5'd0;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_pat       <= SEED;
            r_sig       <= 4'b0000;
            r_cnt       <= 5'd0;
            r_pat_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_RUN: begin
          r_pat <= w_pat_nxt;
          r_sig <= w_sig_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST) begin
            r_state     <= S_CMP;
            r_pat_valid <= 1'b0;
          end
        end
        S_CMP: begin
          r_pass  <= (r_sig == i_exp_sig);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pat       = r_pat;
  assign o_sig       = r_sig;
  assign o_pat_valid = r_pat_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Self-contained BIST session controller: on a start request it drives a 5-bit LFSR pattern stream to an external circuit-under-test (CUT), compresses the CUT's 1-bit response into a 4-bit SISR signature, then compares that signature against an expected value and reports pass/fail. It is the response-evaluating end of the team's LFSR-pattern/SISR-signature BIST scheme. It sequences a session that otherwise free-runs, and turns the raw signature into a verdict for the test host.

## Interface
- `N_PAT`, default 31: number of patterns applied per session. Legal range 1..31.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `start` input, 1 bit: session request, sampled on the clock edge.
- `resp` input, 1 bit: CUT response to the current `pat`, sampled on each RUN edge.
- `exp_sig` input, 4 bits: expected (golden) signature, sampled on the CMP edge.
- `pat` output, 5 bits: current LFSR pattern to the CUT, `pat[4]` is the MSB.
- `pat_valid` output, 1 bit: high while in RUN.
- `busy` output, 1 bit: high in RUN and CMP.
- `done` output, 1 bit: high in DONE.
- `pass` output, 1 bit: verdict. Meaningful only while `done` is high.
- `sig` output, 4 bits: current SISR contents.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on `start`=1.
  - RUN -> CMP after `N_PAT` captures.
  - CMP -> DONE unconditionally.
  - DONE -> RUN on `start`=1. Otherwise DONE holds.
- Reset values: state=IDLE, `pat`=5'b11111, `sig`=4'b0000, pattern counter=0, `pat_valid`=`busy`=`done`=`pass`=0.
- On the IDLE/DONE -> RUN edge:
  - LFSR loads 5'b11111, SISR clears to 0000, counter clears to 0.
  - `done` and `pass` clear.
- LFSR update on each RUN edge, with q=`pat`:
  - q0<=q4
  - q1<=q0
  - q2<=q1^q4
  - q3<=q2
  - q4<=q3
- LFSR sequence from the seed: 11111, 11011, 10011, 00011, ... The all-zero state is never reached; the period is 31.
- SISR update on each RUN edge, with s=`sig` and i=`resp`:
  - s0<=s3^i
  - s1<=s3^s0
  - s2<=s1
  - s3<=s2
- Counter: 5 bits, increments on each RUN edge. The edge on which the counter equals `N_PAT-1` performs the last capture and moves to CMP. The counter never wraps within a session.
- CMP edge: `pass`<=(`sig`==`exp_sig`), `done`<=1, state goes to DONE.
- In CMP and DONE, `pat` and `sig` are frozen. `sig` holds the final signature until the next start.
- In IDLE and DONE with `start`=0, all registers hold.
- `start` is ignored in RUN and CMP; there is no queuing.
- `rst` asserted at any time, including mid-RUN, immediately forces reset values. After release the block waits in IDLE for a new `start`.
- `resp` is ignored outside RUN.

## Timing
- Edge E0 samples `start`=1. After E0: `pat`=11111, `pat_valid`=1.
- Edges E1..E`N_PAT`:
  - Each edge captures `resp` for the pattern visible in the preceding cycle, then advances `pat`.
  - The CUT is combinational: `resp` must be valid within the same cycle `pat` is presented.
- After E`N_PAT`: state=CMP, `pat_valid`=0, `busy`=1.
- E`N_PAT+1` samples `exp_sig`. After it: `done`=1 with valid `pass`, `busy`=0.
- Start-to-`done` latency is `N_PAT+1` edges. Back-to-back sessions are possible: `start` sampled in DONE restarts on that edge.
- `rst` takes effect asynchronously; outputs reach reset values without waiting for a clock edge.
- Deassert `rst` synchronously to `clk`, away from the active edge.

## Test plan
- Reset, then `N_PAT`=4, pulse `start`:
  - `pat` reads 11111, 11011, 10011, 00011 on consecutive RUN cycles.
  - `pat_valid` is high for exactly 4 cycles.
  - `done` rises 5 edges after the start edge.
- `N_PAT`=4, `resp`=1 constant, `exp_sig`=4'b1111:
  - `sig` steps 0001, 0011, 0111, 1111.
  - Result: `pass`=1, `sig`=1111 held in DONE.
- `N_PAT`=4, `resp`=1 constant, `exp_sig`=4'b1110: `pass`=0, `done`=1, `sig`=1111.
- Default `N_PAT`=31, `resp`=0 constant, `exp_sig`=0000:
  - `pass`=1.
  - The 31 observed patterns are all distinct and nonzero.
- `start` pulsed mid-RUN: ignored, and the session ends on schedule. Then:
  - Assert `rst` on RUN cycle 2: `busy`=0, `pat`=11111, `sig`=0000 immediately.
  - The block stays in IDLE until the next `start`.
- Restart from DONE with `start`=1: `done` and `pass` clear on that edge, and a fresh session begins with `pat`=11111 and `sig`=0000.
